// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared register.
// Optional LOCK burst mode enabled by defining SHARED_REG_LOCK_EN.
module shared_reg_arbiter #(
   parameter int N        = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_LOCK = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N-1:0]           req,
   input  logic [N*WIDTH-1:0]     wdata,
`ifdef SHARED_REG_LOCK_EN
   input  logic [N-1:0]           lock,
`endif
   output logic [N-1:0]           gnt,
   output logic [WIDTH-1:0]       Q,
   output logic [$clog2(N)-1:0]   owner,
   output logic                   valid
);

   localparam int IW = $clog2(N);
   localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;

   if (N < 2 || N > 16 || MAX_LOCK < 1) begin : g_bad_param
      $error("shared_reg_arbiter: illegal parameter value");
   end

`ifdef SHARED_REG_LOCK_EN
   typedef enum logic [1:0] {IDLE, GRANT, LOCK} state_t;
`else
   typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

   state_t           state_q, state_d;
   logic [N-1:0]     gnt_q, gnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic             valid_q, valid_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    sel_q, sel_d;
`ifdef SHARED_REG_LOCK_EN
   logic [CW-1:0]    cnt_q, cnt_d;
`endif

   logic [IW-1:0]    win;
   logic [IW:0]      idx;
   logic             found;
   logic [WIDTH-1:0] slice;

   // First requester at or after the pointer, wrapping modulo N
   always_comb begin
      win   = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, ptr_q} + (IW+1)'(k);
         if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
         if (!found && req[idx[IW-1:0]]) begin
            win   = idx[IW-1:0];
            found = 1'b1;
         end
      end
   end

   assign slice = wdata[int'(sel_q)*WIDTH +: WIDTH];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      q_d     = q_q;
      owner_d = owner_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
`ifdef SHARED_REG_LOCK_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            gnt_d = '0;
            if (found) begin
               gnt_d[win] = 1'b1;
               sel_d      = win;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            q_d     = slice;
            owner_d = sel_q;
            valid_d = 1'b1;
            ptr_d   = (sel_q == IW'(N-1)) ? '0 : sel_q + 1'b1;
            gnt_d   = '0;
            state_d = IDLE;
`ifdef SHARED_REG_LOCK_EN
            if (lock[sel_q]) begin
               gnt_d   = gnt_q;
               cnt_d   = '0;
               state_d = LOCK;
            end
`endif
         end
`ifdef SHARED_REG_LOCK_EN
         LOCK: begin
            if (req[sel_q]) q_d = slice;
            cnt_d = cnt_q + 1'b1;
            if (!lock[sel_q] || cnt_q == CW'(MAX_LOCK-1)) begin
               gnt_d   = '0;
               state_d = IDLE;
            end
         end
`endif
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         q_q     <= '0;
         owner_q <= '0;
         valid_q <= 1'b0;
         ptr_q   <= '0;
         sel_q   <= '0;
`ifdef SHARED_REG_LOCK_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         q_q     <= q_d;
         owner_q <= owner_d;
         valid_q <= valid_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
`ifdef SHARED_REG_LOCK_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   assign gnt   = gnt_q;
   assign Q     = q_q;
   assign owner = owner_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Randomised and directed bench for shared_reg_arbiter against a
// behavioural model; also covers SHARED_REG_LOCK_EN builds.
module tb_shared_reg_arbiter;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int ML = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req;
   logic [N-1:0]   lock_v;
   logic [N*W-1:0] wdata;
   logic [N-1:0]   gnt;
   logic [W-1:0]   Q;
   logic [1:0]     owner;
   logic           valid;

   int checks = 0;
   int errors = 0;

   // reference model
   int m_ptr, m_w, m_cnt, m_q, m_owner;
   bit m_grant, m_lock, m_valid;

   always #5 clk = ~clk;

   shared_reg_arbiter #(.N(N), .WIDTH(W), .MAX_LOCK(ML)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .wdata (wdata),
`ifdef SHARED_REG_LOCK_EN
      .lock  (lock_v),
`endif
      .gnt   (gnt),
      .Q     (Q),
      .owner (owner),
      .valid (valid)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick();
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req[i]) return i;
      end
      return 0;
   endfunction

   task automatic model_edge();
      logic [N-1:0] lk;
      lk = '0;
`ifdef SHARED_REG_LOCK_EN
      lk = lock_v;
`endif
      if (reset) begin
         m_ptr = 0; m_w = 0; m_cnt = 0; m_q = 0; m_owner = 0;
         m_grant = 0; m_lock = 0; m_valid = 0;
      end else if (m_lock) begin
         if (req[m_w]) m_q = int'(wdata[m_w*W +: W]);
         if (!lk[m_w] || m_cnt == ML-1) m_lock = 0;
         else m_cnt++;
      end else if (m_grant) begin
         m_grant = 0;
         m_q = int'(wdata[m_w*W +: W]);
         m_owner = m_w;
         m_valid = 1;
         m_ptr = (m_w + 1) % N;
         if (lk[m_w]) begin
            m_lock = 1;
            m_cnt = 0;
         end
      end else if (req != 0) begin
         m_w = pick();
         m_grant = 1;
      end
   endtask

   task automatic step();
      logic [N-1:0] eg;
      @(posedge clk);
      model_edge();
      #1;
      eg = '0;
      if (m_grant || m_lock) eg[m_w] = 1'b1;
      chk("gnt",   32'(gnt),   32'(eg));
      chk("Q",     32'(Q),     32'(m_q));
      chk("owner", 32'(owner), 32'(m_owner));
      chk("valid", 32'(valid), 32'(m_valid));
   endtask

   task automatic set_slice(input int i, input logic [W-1:0] v);
      wdata[i*W +: W] = v;
   endtask

   initial begin
      reset = 1'b1; req = '0; lock_v = '0; wdata = '0;
      m_ptr = 0; m_w = 0; m_cnt = 0; m_q = 0; m_owner = 0;
      m_grant = 0; m_lock = 0; m_valid = 0;

      // reset then idle
      step(); step();
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) step();
      chk("idle_Q", 32'(Q), 32'h0);
      chk("idle_valid", 32'(valid), 32'h0);

      // single write
      req = 4'b0100; set_slice(2, 8'hA5);
      step();
      chk("single_gnt", 32'(gnt), 32'h4);
      req = '0;
      step();
      chk("single_Q", 32'(Q), 32'hA5);
      chk("single_owner", 32'(owner), 32'd2);
      chk("single_gnt0", 32'(gnt), 32'h0);

      // round robin from a clean pointer
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < N; i++) set_slice(i, W'(8'h10 + i));
      for (int g = 0; g < 5; g++) begin
         step();
         chk("rr_gnt", 32'(gnt), 32'(1 << (g % N)));
         step();
         chk("rr_Q", 32'(Q), 32'(8'h10 + (g % N)));
      end
      req = '0; step(); step();

      // pointer wrap and skip
      req = 4'b1000; set_slice(3, 8'h33);
      step(); req = '0; step();
      chk("wrap_owner", 32'(owner), 32'd3);
      req = 4'b0011;
      step();
      chk("wrap_gnt0", 32'(gnt), 32'h1);
      req = 4'b0010;
      step(); step();
      chk("wrap_gnt1", 32'(gnt), 32'h2);
      step(); req = '0; step();

      // reset during grant
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b0010; set_slice(1, 8'h5A);
      step();
      chk("midrst_gnt", 32'(gnt), 32'h2);
      reset = 1'b1;
      step();
      reset = 1'b0; req = '0;
      chk("midrst_Q", 32'(Q), 32'h0);
      chk("midrst_valid", 32'(valid), 32'h0);
      step();

`ifdef SHARED_REG_LOCK_EN
      // lock burst bounded by MAX_LOCK
      reset = 1'b1; step(); reset = 1'b0;
      req = 4'b0011; lock_v = 4'b0001; set_slice(0, 8'h01);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("lock_gnt", 32'(gnt), 32'h1);
         step();
         set_slice(0, W'(i + 2));
      end
      chk("lock_Q", 32'(Q), 32'h05);
      step();
      chk("lock_next", 32'(gnt), 32'h2);
      req = '0; lock_v = '0;
      step(); step();
`endif

      // randomised traffic
      for (int c = 0; c < 800; c++) begin
         reset  = ($urandom_range(0, 39) == 0);
         req    = N'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         lock_v = N'($urandom);
         wdata  = (N*W)'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
